// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequences one HI/LO-writing instruction at a time.
// It launches the multiplier or divider, waits for the matching completion
// (bounded by TIMEOUT cycles), then pulses the HI/LO write-data selects and
// write enables for a single WRITE cycle. All outputs come from flops.
module hilo_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic OP_VALID,
    input  logic [2:0] OP_CODE,
    input  logic DIV_ZERO,
    input  logic MULT_DONE,
    input  logic DIV_DONE,
    output logic MULT_START,
    output logic DIV_START,
    output logic MULT_SIGNED,
    output logic DIV_SIGNED,
    output logic MUX_HI_WDATA_DIV,
    output logic MUX_HI_WDATA_MULT,
    output logic MUX_HI_WDATA_RS,
    output logic MUX_LO_WDATA_DIV,
    output logic MUX_LO_WDATA_MULT,
    output logic MUX_LO_WDATA_RS,
    output logic HI_WENA,
    output logic LO_WENA,
    output logic BUSY,
    output logic DONE,
    output logic DIVZERO_ERR,
    output logic TIMEOUT_ERR
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Value of the wait counter in the last permitted WAIT cycle.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] OP_MULT = 3'b000;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MULT_WAIT = 2'd1,
        ST_DIV_WAIT  = 2'd2,
        ST_WRITE     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            divz_q, divz_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            abort_d;

    // Registered output bundle; bit order matches the port assignments below.
    logic [15:0]     out_q, out_d;

    logic is_mult_op, is_div_op, in_write;
    logic busy_d, done_d, mult_start_d, div_start_d, mult_signed_d, div_signed_d;
    logic hi_div_d, hi_mult_d, hi_rs_d, lo_div_d, lo_mult_d, lo_rs_d;
    logic hi_wena_d, lo_wena_d, dz_err_d, to_err_d;

    // Next-state logic: acceptance, completion wait with timeout, single WRITE cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        divz_d  = divz_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (OP_VALID && (OP_CODE[2:1] != 2'b11)) begin
                    op_d   = OP_CODE;
                    divz_d = DIV_ZERO && (OP_CODE[2:1] == 2'b01);
                    cnt_d  = '0;
                    if (OP_CODE[2]) begin
                        state_d = ST_WRITE;
                    end else if (!OP_CODE[1]) begin
                        state_d = ST_MULT_WAIT;
                    end else if (DIV_ZERO) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_DIV_WAIT;
                    end
                end
            end
            ST_MULT_WAIT: begin
                if (MULT_DONE) begin
                    state_d = ST_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DIV_WAIT: begin
                if (DIV_DONE) begin
                    state_d = ST_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state and latched op, so outputs are registered Moore values.
    always_comb begin
        is_mult_op    = (op_d[2:1] == 2'b00);
        is_div_op     = (op_d[2:1] == 2'b01);
        in_write      = (state_d == ST_WRITE);
        busy_d        = (state_d != ST_IDLE);
        done_d        = in_write;
        mult_start_d  = (state_d == ST_MULT_WAIT) && (state_q != ST_MULT_WAIT);
        div_start_d   = (state_d == ST_DIV_WAIT) && (state_q != ST_DIV_WAIT);
        mult_signed_d = ((state_d == ST_MULT_WAIT) || in_write) && (op_d == OP_MULT);
        div_signed_d  = ((state_d == ST_DIV_WAIT) || in_write) && (op_d == OP_DIV) && !divz_d;
        hi_mult_d     = in_write && is_mult_op;
        lo_mult_d     = in_write && is_mult_op;
        hi_div_d      = in_write && is_div_op && !divz_d;
        lo_div_d      = in_write && is_div_op && !divz_d;
        hi_rs_d       = in_write && (op_d == OP_MTHI);
        lo_rs_d       = in_write && (op_d == OP_MTLO);
        hi_wena_d     = hi_mult_d || hi_div_d || hi_rs_d;
        lo_wena_d     = lo_mult_d || lo_div_d || lo_rs_d;
        dz_err_d      = in_write && is_div_op && divz_d;
        to_err_d      = abort_d;
        out_d = {busy_d, done_d, mult_start_d, div_start_d, mult_signed_d, div_signed_d,
                 hi_div_d, hi_mult_d, hi_rs_d, lo_div_d, lo_mult_d, lo_rs_d,
                 hi_wena_d, lo_wena_d, dz_err_d, to_err_d};
    end

    // State, latched operation, wait counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 3'b000;
            divz_q  <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            divz_q  <= divz_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign BUSY              = out_q[15];
    assign DONE              = out_q[14];
    assign MULT_START        = out_q[13];
    assign DIV_START         = out_q[12];
    assign MULT_SIGNED       = out_q[11];
    assign DIV_SIGNED        = out_q[10];
    assign MUX_HI_WDATA_DIV  = out_q[9];
    assign MUX_HI_WDATA_MULT = out_q[8];
    assign MUX_HI_WDATA_RS   = out_q[7];
    assign MUX_LO_WDATA_DIV  = out_q[6];
    assign MUX_LO_WDATA_MULT = out_q[5];
    assign MUX_LO_WDATA_RS   = out_q[4];
    assign HI_WENA           = out_q[3];
    assign LO_WENA           = out_q[2];
    assign DIVZERO_ERR       = out_q[1];
    assign TIMEOUT_ERR       = out_q[0];

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: table of per-instruction pulse counts, a cycle-level
// expected-trace model built from the instruction rules, randomized traffic
// with stray requests/completions, and hand sequences for reset and timeout.
module tb_hilo_ctrl;

    localparam int TMO = 8;

    localparam int B_BUSY = 15, B_DONE = 14, B_MST = 13, B_DST = 12, B_MSG = 11, B_DSG = 10;
    localparam int B_HDIV = 9, B_HMUL = 8, B_HRS = 7, B_LDIV = 6, B_LMUL = 5, B_LRS = 4;
    localparam int B_HWE = 3, B_LWE = 2, B_DZ = 1, B_TO = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic op_valid = 1'b0;
    logic [2:0] op_code = 3'b000;
    logic div_zero = 1'b0;
    logic mult_done = 1'b0;
    logic div_done = 1'b0;
    logic mult_start, div_start, mult_signed, div_signed;
    logic hi_div, hi_mult, hi_rs, lo_div, lo_mult, lo_rs;
    logic hi_wena, lo_wena, busy, done, dz_err, to_err;
    logic [15:0] obs;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    hilo_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .OP_VALID(op_valid), .OP_CODE(op_code), .DIV_ZERO(div_zero),
        .MULT_DONE(mult_done), .DIV_DONE(div_done), .MULT_START(mult_start), .DIV_START(div_start),
        .MULT_SIGNED(mult_signed), .DIV_SIGNED(div_signed),
        .MUX_HI_WDATA_DIV(hi_div), .MUX_HI_WDATA_MULT(hi_mult), .MUX_HI_WDATA_RS(hi_rs),
        .MUX_LO_WDATA_DIV(lo_div), .MUX_LO_WDATA_MULT(lo_mult), .MUX_LO_WDATA_RS(lo_rs),
        .HI_WENA(hi_wena), .LO_WENA(lo_wena), .BUSY(busy), .DONE(done),
        .DIVZERO_ERR(dz_err), .TIMEOUT_ERR(to_err)
    );

    assign obs = {busy, done, mult_start, div_start, mult_signed, div_signed,
                  hi_div, hi_mult, hi_rs, lo_div, lo_mult, lo_rs, hi_wena, lo_wena, dz_err, to_err};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Expected per-cycle outputs, starting with the cycle after acceptance.
    // k = edge (relative to acceptance) at which the matching completion is sampled; 0 = never.
    task automatic build_trace(input logic [2:0] op, input logic dz, input int k);
        logic [15:0] v;
        bit is_mult, sgn, completes;
        int wait_n;
        exp_q.delete();
        if (op[2:1] == 2'b11) begin
            exp_q.push_back(16'h0);
            return;
        end
        if (op == 3'b100 || op == 3'b101) begin
            v = '0;
            v[B_BUSY] = 1'b1;
            v[B_DONE] = 1'b1;
            if (op == 3'b100) begin v[B_HRS] = 1'b1; v[B_HWE] = 1'b1; end
            else begin v[B_LRS] = 1'b1; v[B_LWE] = 1'b1; end
            exp_q.push_back(v);
            exp_q.push_back(16'h0);
            return;
        end
        is_mult = (op[1] == 1'b0);
        sgn = (op[0] == 1'b0);
        if (!is_mult && dz) begin
            v = '0;
            v[B_BUSY] = 1'b1;
            v[B_DONE] = 1'b1;
            v[B_DZ] = 1'b1;
            exp_q.push_back(v);
            exp_q.push_back(16'h0);
            return;
        end
        completes = (k >= 1 && k <= TMO);
        wait_n = completes ? k : TMO;
        for (int c = 0; c < wait_n; c++) begin
            v = '0;
            v[B_BUSY] = 1'b1;
            if (c == 0) v[is_mult ? B_MST : B_DST] = 1'b1;
            if (sgn) v[is_mult ? B_MSG : B_DSG] = 1'b1;
            exp_q.push_back(v);
        end
        v = '0;
        if (completes) begin
            v[B_BUSY] = 1'b1;
            v[B_DONE] = 1'b1;
            if (sgn) v[is_mult ? B_MSG : B_DSG] = 1'b1;
            v[is_mult ? B_HMUL : B_HDIV] = 1'b1;
            v[is_mult ? B_LMUL : B_LDIV] = 1'b1;
            v[B_HWE] = 1'b1;
            v[B_LWE] = 1'b1;
        end else begin
            v[B_TO] = 1'b1;
        end
        exp_q.push_back(v);
        exp_q.push_back(16'h0);
    endtask

    // Issue one request from IDLE and compare every following cycle with the trace.
    // mode 0: quiet; 1: random stray requests/completions while busy; 2: stray on every busy cycle.
    task automatic run_trace(input int id, input logic [2:0] op, input logic dz, input int k, input int mode);
        bit is_mult;
        bit noise;
        int bad0;
        bad0 = failures;
        is_mult = (op[1] == 1'b0);
        build_trace(op, dz, k);
        op_valid = 1'b1;
        op_code = op;
        div_zero = dz;
        step();
        op_valid = 1'b0;
        div_zero = 1'b0;
        for (int c = 0; c < exp_q.size(); c++) begin
            noise = exp_q[c][B_BUSY] && (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0));
            mult_done = 1'b0;
            div_done = 1'b0;
            op_valid = 1'b0;
            if (op[2] == 1'b0 && k >= 1 && c == k - 1) begin
                if (is_mult) mult_done = 1'b1;
                else div_done = 1'b1;
            end
            if (noise) begin
                if (op[2] == 1'b0) begin
                    if (is_mult) div_done = 1'b1;
                    else mult_done = 1'b1;
                end
                op_valid = 1'b1;
                op_code = (mode == 2) ? 3'b100 : 3'($urandom_range(0, 7));
            end
            chk_vec($sformatf("txn%0d_cycle%0d", id, c), obs, exp_q[c]);
            step();
        end
        mult_done = 1'b0;
        div_done = 1'b0;
        op_valid = 1'b0;
        $display("txn %0d op=%b dz=%0d k=%0d mode=%0d cycles=%0d errs=%0d",
                 id, op, dz, k, mode, exp_q.size(), failures - bad0);
    endtask

    typedef struct {
        logic [2:0] op;
        logic dz;
        int k;
        int busy_n, hi_we_n, lo_we_n, done_n, dz_n, to_n, ms_n, ds_n;
    } vec_t;

    vec_t tbl[12];

    // Apply one table record and compare pulse counts over a fixed 16-cycle window.
    task automatic run_vec(input int id, input vec_t v);
        int cb, ch, cl, cd, cz, ct, cm, cs;
        cb = 0; ch = 0; cl = 0; cd = 0; cz = 0; ct = 0; cm = 0; cs = 0;
        op_valid = 1'b1;
        op_code = v.op;
        div_zero = v.dz;
        step();
        op_valid = 1'b0;
        div_zero = 1'b0;
        for (int c = 0; c < 16; c++) begin
            mult_done = (v.op[2:1] == 2'b00) && (v.k >= 1) && (c == v.k - 1);
            div_done  = (v.op[2:1] == 2'b01) && (v.k >= 1) && (c == v.k - 1);
            cb += int'(busy); ch += int'(hi_wena); cl += int'(lo_wena); cd += int'(done);
            cz += int'(dz_err); ct += int'(to_err); cm += int'(mult_start); cs += int'(div_start);
            step();
        end
        mult_done = 1'b0;
        div_done = 1'b0;
        chk_int($sformatf("vec%0d_busy_cycles", id), cb, v.busy_n);
        chk_int($sformatf("vec%0d_hi_wena", id), ch, v.hi_we_n);
        chk_int($sformatf("vec%0d_lo_wena", id), cl, v.lo_we_n);
        chk_int($sformatf("vec%0d_done", id), cd, v.done_n);
        chk_int($sformatf("vec%0d_divzero_err", id), cz, v.dz_n);
        chk_int($sformatf("vec%0d_timeout_err", id), ct, v.to_n);
        chk_int($sformatf("vec%0d_mult_start", id), cm, v.ms_n);
        chk_int($sformatf("vec%0d_div_start", id), cs, v.ds_n);
        $display("vec %0d op=%b dz=%0d k=%0d busy=%0d hi=%0d lo=%0d done=%0d dz=%0d to=%0d ms=%0d ds=%0d",
                 id, v.op, v.dz, v.k, cb, ch, cl, cd, cz, ct, cm, cs);
    endtask

    initial begin
        logic [15:0] v;
        tbl[0]  = '{3'b101, 1'b0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{3'b100, 1'b0, 0, 1, 1, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{3'b001, 1'b0, 4, 5, 1, 1, 1, 0, 0, 1, 0};
        tbl[3]  = '{3'b000, 1'b0, 1, 2, 1, 1, 1, 0, 0, 1, 0};
        tbl[4]  = '{3'b010, 1'b0, 3, 4, 1, 1, 1, 0, 0, 0, 1};
        tbl[5]  = '{3'b011, 1'b0, 8, 9, 1, 1, 1, 0, 0, 0, 1};
        tbl[6]  = '{3'b010, 1'b1, 0, 1, 0, 0, 1, 1, 0, 0, 0};
        tbl[7]  = '{3'b011, 1'b1, 2, 1, 0, 0, 1, 1, 0, 0, 0};
        tbl[8]  = '{3'b010, 1'b0, 0, 8, 0, 0, 0, 0, 1, 0, 1};
        tbl[9]  = '{3'b001, 1'b0, 0, 8, 0, 0, 0, 0, 1, 1, 0};
        tbl[10] = '{3'b110, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{3'b111, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Asynchronous reset with no clock edge involved.
        #1 rst_n = 1'b0;
        #1 chk_vec("reset_state", obs, 16'h0);
        #21 rst_n = 1'b1;
        step();
        chk_vec("after_release", obs, 16'h0);

        // MTLO right after reset, then a second MTLO in the trailing IDLE cycle.
        op_valid = 1'b1; op_code = 3'b101;
        step();
        op_valid = 1'b0;
        v = '0; v[B_BUSY] = 1; v[B_DONE] = 1; v[B_LRS] = 1; v[B_LWE] = 1;
        chk_vec("mtlo_write", obs, v);
        step();
        chk_vec("mtlo_idle", obs, 16'h0);
        op_valid = 1'b1; op_code = 3'b101;
        step();
        op_valid = 1'b0;
        chk_vec("mtlo_back_to_back", obs, v);
        step();
        chk_vec("mtlo2_idle", obs, 16'h0);

        for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

        // Stray MTHI request and stray divider completion while waiting on the multiplier.
        run_trace(100, 3'b000, 1'b0, 3, 2);
        run_trace(101, 3'b011, 1'b0, 5, 2);

        // Timeout on DIV, with an MTHI accepted in the TIMEOUT_ERR cycle.
        op_valid = 1'b1; op_code = 3'b010; div_zero = 1'b0;
        step();
        op_valid = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            chk_int($sformatf("tmo_busy_c%0d", c), int'(busy && !hi_wena && !lo_wena && !done), 1);
            step();
        end
        v = '0; v[B_TO] = 1;
        chk_vec("tmo_err_cycle", obs, v);
        op_valid = 1'b1; op_code = 3'b100;
        step();
        op_valid = 1'b0;
        v = '0; v[B_BUSY] = 1; v[B_DONE] = 1; v[B_HRS] = 1; v[B_HWE] = 1;
        chk_vec("mthi_after_timeout", obs, v);
        step();
        chk_vec("mthi_after_timeout_idle", obs, 16'h0);
        $display("txn tmo_then_mthi done");

        // Reset in the middle of DIV_WAIT; a late DIV_DONE must not cause a write.
        op_valid = 1'b1; op_code = 3'b010;
        step();
        op_valid = 1'b0;
        step();
        chk_int("div_wait_busy", int'(busy), 1);
        #3 rst_n = 1'b0;
        #1 chk_vec("midcycle_reset", obs, 16'h0);
        #3 rst_n = 1'b1;
        step();
        div_done = 1'b1;
        step();
        div_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk_vec($sformatf("post_reset_idle_c%0d", c), obs, 16'h0);
            step();
        end
        $display("txn reset_in_div_wait done");

        // Reset asserted during the WRITE cycle of an MTHI.
        op_valid = 1'b1; op_code = 3'b100;
        step();
        op_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_vec("reset_in_write", obs, 16'h0);
        #2 rst_n = 1'b1;
        step();
        chk_vec("reset_in_write_idle", obs, 16'h0);
        $display("txn reset_in_write done");

        // Randomized traffic against the trace model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] rop;
            logic rdz;
            int rk;
            rop = 3'($urandom_range(0, 7));
            rdz = ($urandom_range(0, 3) == 0);
            rk  = $urandom_range(0, 12);
            run_trace(i, rop, rdz, rk, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
